mesh_result_drain: RTL and testbench

//  Downstream of the mesh top: captures the ROWS-wide result_flat word on each mesh done pulse and

---
 rtl/mesh_pkg.sv | 21 ++
 rtl/mesh_result_bank.sv | 32 +++
 rtl/mesh_result_drain.sv | 118 +++++++++++
 tb/tb_mesh_result_drain.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/mesh_pkg.sv
// Shared widths, read-FSM encoding and row-slice helper for the mesh result drain.
package mesh_pkg;

    localparam int unsigned DW    = 8;
    localparam int unsigned ROWS  = 4;
    localparam int unsigned ROW_W = 2;
    localparam int unsigned RES_W = 2 * DW;
    localparam int unsigned FLAT_W = ROWS * RES_W;

    typedef enum logic {
        S_IDLE   = 1'b0,
        S_STREAM = 1'b1
    } rd_state_e;

    // Row i occupies flat[(i+1)*RES_W-1 -: RES_W].
    function automatic logic [RES_W-1:0] get_row(input logic [FLAT_W-1:0] flat,
                                                 input logic [ROW_W-1:0]  idx);
        return flat[RES_W * 32'(idx) +: RES_W];
    endfunction

endpackage

// File: rtl/mesh_result_bank.sv
// One capture bank: a full ROWS*RES_W result word plus its full flag; load wins over clear.
module mesh_result_bank
    import mesh_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              load_i,
    input  logic              clr_i,
    input  logic [FLAT_W-1:0] data_i,
    output logic [FLAT_W-1:0] data_o,
    output logic              full_o
);

    logic [FLAT_W-1:0] data_q;
    logic              full_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            data_q <= '0;
            full_q <= 1'b0;
        end else if (load_i) begin
            data_q <= data_i;
            full_q <= 1'b1;
        end else if (clr_i) begin
            full_q <= 1'b0;
        end
    end

    assign data_o = data_q;
    assign full_o = full_q;

endmodule

// File: rtl/mesh_result_drain.sv
// Double-buffered capture of mesh results, streamed out one row per valid/ready transfer.
module mesh_result_drain
    import mesh_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              done,
    input  logic [FLAT_W-1:0] result_flat,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [RES_W-1:0]  out_data,
    output logic [ROW_W-1:0]  out_row,
    output logic              out_last,
    output logic              busy,
    output logic              overflow,
    input  logic              clr_ovf
);

    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(ROWS - 1);

    rd_state_e          state_q;
    logic [ROW_W-1:0]   row_q;
    logic               rd_ptr_q;
    logic               wr_ptr_q;

    logic [1:0]         bank_full;
    logic [FLAT_W-1:0]  bank_data [2];
    logic [1:0]         bank_load;
    logic [1:0]         bank_clr;
    logic [1:0]         full_nx;
    logic [FLAT_W-1:0]  data_nx [2];

    logic hs_c, last_hs_c, capture_c, drop_c, next_ptr_c;

    for (genvar b = 0; b < 2; b++) begin : g_bank
        mesh_result_bank u_bank (
            .clk    (clk),
            .rst    (rst),
            .load_i (bank_load[b]),
            .clr_i  (bank_clr[b]),
            .data_i (result_flat),
            .data_o (bank_data[b]),
            .full_o (bank_full[b])
        );
    end

    // A done into a full write bank is still accepted when that bank frees on this edge.
    always_comb begin
        hs_c       = out_valid & out_ready;
        last_hs_c  = hs_c & (row_q == LAST_ROW);
        capture_c  = done & (~bank_full[wr_ptr_q] | (last_hs_c & (wr_ptr_q == rd_ptr_q)));
        drop_c     = done & ~capture_c;
        next_ptr_c = ~rd_ptr_q;
        bank_load  = '0;
        bank_clr   = '0;
        full_nx    = '0;
        for (int b = 0; b < 2; b++) begin
            bank_load[b] = capture_c & (wr_ptr_q == 1'(b));
            bank_clr[b]  = last_hs_c & (rd_ptr_q == 1'(b));
            full_nx[b]   = bank_load[b] | (bank_full[b] & ~bank_clr[b]);
            data_nx[b]   = bank_load[b] ? result_flat : bank_data[b];
        end
    end

    // Read FSM with registered outputs looking at next-edge bank contents, so a fresh capture shows at once.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            row_q     <= '0;
            rd_ptr_q  <= 1'b0;
            wr_ptr_q  <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
            busy      <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_q ^ capture_c;
            busy     <= |full_nx;
            if (drop_c) begin
                overflow <= 1'b1;
            end else if (clr_ovf) begin
                overflow <= 1'b0;
            end
            case (state_q)
                S_IDLE: begin
                    if (full_nx[rd_ptr_q]) begin
                        state_q   <= S_STREAM;
                        out_valid <= 1'b1;
                        row_q     <= '0;
                        out_last  <= (LAST_ROW == '0);
                        out_data  <= get_row(data_nx[rd_ptr_q], '0);
                    end
                end
                S_STREAM: begin
                    if (last_hs_c) begin
                        rd_ptr_q <= next_ptr_c;
                        row_q    <= '0;
                        out_last <= (LAST_ROW == '0);
                        out_data <= get_row(data_nx[next_ptr_c], '0);
                        if (!full_nx[next_ptr_c]) begin
                            state_q   <= S_IDLE;
                            out_valid <= 1'b0;
                        end
                    end else if (hs_c) begin
                        row_q    <= ROW_W'(row_q + 1'b1);
                        out_last <= (ROW_W'(row_q + 1'b1) == LAST_ROW);
                        out_data <= get_row(data_nx[rd_ptr_q], ROW_W'(row_q + 1'b1));
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign out_row = row_q;

endmodule

// File: tb/tb_mesh_result_drain.sv
// Randomized and directed bench for mesh_result_drain against a queue-of-rows reference model.
module tb_mesh_result_drain;
    import mesh_pkg::*;

    logic              clk = 1'b0;
    logic              rst;
    logic              done;
    logic [FLAT_W-1:0] result_flat;
    logic              out_valid;
    logic              out_ready;
    logic [RES_W-1:0]  out_data;
    logic [ROW_W-1:0]  out_row;
    logic              out_last;
    logic              busy;
    logic              overflow;
    logic              clr_ovf;

    int errs   = 0;
    int checks = 0;

    // Model: every not-yet-accepted row as {row, data}, oldest first.
    logic [ROW_W+RES_W-1:0] exp_q[$];
    bit m_ovf    = 0;
    bit after_rst = 1;

    mesh_result_drain dut (
        .clk         (clk),
        .rst         (rst),
        .done        (done),
        .result_flat (result_flat),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_row     (out_row),
        .out_last    (out_last),
        .busy        (busy),
        .overflow    (overflow),
        .clr_ovf     (clr_ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [FLAT_W-1:0] mk(input int a, input int b, input int c, input int d);
        return {RES_W'(d), RES_W'(c), RES_W'(b), RES_W'(a)};
    endfunction

    function automatic logic [FLAT_W-1:0] rnd_flat();
        return FLAT_W'({$urandom, $urandom});
    endfunction

    task automatic compare();
        logic [ROW_W+RES_W-1:0] h;
        check("out_valid", 32'(out_valid), 32'(exp_q.size() != 0));
        check("busy", 32'(busy), 32'(exp_q.size() != 0));
        check("overflow", 32'(overflow), 32'(m_ovf));
        if (exp_q.size() != 0) begin
            h = exp_q[0];
            check("out_data", 32'(out_data), 32'(h[RES_W-1:0]));
            check("out_row", 32'(out_row), 32'(h[RES_W +: ROW_W]));
            check("out_last", 32'(out_last), 32'(h[RES_W +: ROW_W] == ROW_W'(ROWS - 1)));
        end else if (after_rst) begin
            check("rst_data", 32'(out_data), 32'd0);
            check("rst_row", 32'(out_row), 32'd0);
            check("rst_last", 32'(out_last), 32'd0);
        end
        after_rst = 0;
    endtask

    // Apply the rules to the inputs seen at this edge.
    task automatic model_edge();
        int  ncap;
        bit  hs, lh;
        if (rst) begin
            exp_q.delete();
            m_ovf = 0;
            after_rst = 1;
            return;
        end
        hs   = (exp_q.size() != 0) && out_ready;
        lh   = hs && (exp_q[0][RES_W +: ROW_W] == ROW_W'(ROWS - 1));
        ncap = (exp_q.size() + ROWS - 1) / ROWS;
        if (hs) void'(exp_q.pop_front());
        if (done && (ncap < 2 || (ncap == 2 && lh))) begin
            for (int i = 0; i < ROWS; i++)
                exp_q.push_back({ROW_W'(i), result_flat[i*RES_W +: RES_W]});
            if (clr_ovf) m_ovf = 0;
        end else if (done) begin
            m_ovf = 1;
        end else if (clr_ovf) begin
            m_ovf = 0;
        end
    endtask

    task automatic cyc(input bit d, input logic [FLAT_W-1:0] f, input bit rdy, input bit c, input bit r);
        @(negedge clk);
        compare();
        done        = d;
        result_flat = f;
        out_ready   = rdy;
        clr_ovf     = c;
        rst         = r;
        @(posedge clk);
        model_edge();
    endtask

    task automatic idle(input int n, input bit rdy);
        for (int i = 0; i < n; i++) cyc(0, rnd_flat(), rdy, 0, 0);
    endtask

    initial begin
        rst = 1; done = 0; result_flat = '0; out_ready = 0; clr_ovf = 0;
        repeat (2) @(posedge clk);

        // single capture, free-flowing consumer
        cyc(1, mk(10, 20, 30, 40), 1, 0, 0);
        idle(6, 1);

        // backpressure pattern 1,0,0,1
        cyc(1, mk(11, 22, 33, 44), 1, 0, 0);
        for (int i = 0; i < 16; i++) cyc(0, rnd_flat(), (i % 4 == 0) || (i % 4 == 3), 0, 0);

        // two dones two cycles apart, no bubble between sets
        cyc(1, mk(1, 2, 3, 4), 1, 0, 0);
        cyc(0, rnd_flat(), 1, 0, 0);
        cyc(1, mk(5, 6, 7, 8), 1, 0, 0);
        idle(10, 1);

        // overflow on third done, then clear and drain
        cyc(1, mk(100, 101, 102, 103), 0, 0, 0);
        cyc(0, rnd_flat(), 0, 0, 0);
        cyc(1, mk(200, 201, 202, 203), 0, 0, 0);
        cyc(0, rnd_flat(), 0, 0, 0);
        cyc(1, mk(300, 301, 302, 303), 0, 0, 0);
        idle(2, 0);
        cyc(0, rnd_flat(), 0, 1, 0);
        idle(12, 1);

        // done coincident with last-row handshake while both banks full
        cyc(1, mk(7, 7, 7, 7), 0, 0, 0);
        cyc(1, mk(8, 8, 8, 8), 0, 0, 0);
        idle(3, 1);
        cyc(1, mk(9, 9, 9, 9), 1, 0, 0);
        idle(12, 1);

        // reset mid-stream, then restart
        cyc(1, mk(50, 51, 52, 53), 1, 0, 0);
        idle(2, 1);
        cyc(0, rnd_flat(), 1, 0, 1);
        idle(1, 1);
        cyc(1, mk(60, 61, 62, 63), 1, 0, 0);
        idle(6, 1);

        // random traffic
        for (int i = 0; i < 800; i++)
            cyc(($urandom % 4) == 0, rnd_flat(), ($urandom % 3) != 0,
                ($urandom % 16) == 0, ($urandom % 150) == 0);
        idle(20, 1);
        @(negedge clk);
        compare();

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
